cd_host_comm: RTL and testbench

- Host-side nibble-serial engine for the CD drive (CDD) link in the NeoGeo CD system.
- On each drive IRQ it acknowledges, receives the 10-nibble status packet, then transmits the 10-nibble command packet.
- The handshake uses HOCK (host strobe) and CDCK (drive strobe).
- The CPU side gets a command shadow buffer, a status readback buffer and error flags.
- Sits between the CPU/register decode and the CDD MCU.

---
 rtl/cd_comm_pkg.sv | 31 +++
 rtl/cd_hs_wait.sv | 49 ++++
 rtl/cd_host_comm.sv | 202 ++++++++++++++++++++
 tb/tb_cd_host_comm.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_comm_pkg.sv
// Shared types and checksum helper for the host side of the CD drive nibble link.
package cd_comm_pkg;

    localparam int unsigned PKT_LEN  = 10;
    localparam int unsigned CHK_IDX  = 9;
    localparam logic [7:0]  CHK_BIAS = 8'd5;

    typedef enum logic [3:0] {
        StIdle,
        StAck,
        StRxWait,
        StRxAck,
        StChk,
        StTxSetup,
        StTxHi,
        StTxLo,
        StDone,
        StRecover
    } cd_state_e;

    // Packet check nibble: inverted low nibble of the biased 8-bit sum of nibbles 0..8.
    function automatic logic [3:0] cd_nibble_chk(input logic [CHK_IDX-1:0][3:0] nib);
        logic [7:0] acc;
        acc = CHK_BIAS;
        for (int unsigned k = 0; k < CHK_IDX; k++) begin
            acc = acc + {4'h0, nib[k]};
        end
        return ~acc[3:0];
    endfunction

endpackage

// File: rtl/cd_hs_wait.sv
// Handshake wait helper: settle hold after a condition is first met, plus a per-state timeout.
module cd_hs_wait #(
    parameter int unsigned HOLD    = 96,
    parameter int unsigned TIMEOUT = 16383
) (
    input  logic CLK_12M,
    input  logic nRESET,
    input  logic cond,
    input  logic restart,
    output logic go,
    output logic timeout
);

    localparam int unsigned HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [HW-1:0] hold_q;
    logic          armed_q;
    logic [TW-1:0] to_q;

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
            to_q    <= '0;
        end else if (restart) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
            to_q    <= '0;
        end else begin
            if (to_q != TW'(TIMEOUT)) begin
                to_q <= to_q + 1'b1;
            end
            // Once armed the hold runs to completion; the condition is only a trigger.
            if (!armed_q) begin
                if (cond) begin
                    armed_q <= 1'b1;
                    hold_q  <= HW'(HOLD);
                end
            end else if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    assign go      = armed_q && (hold_q == '0);
    assign timeout = (to_q == TW'(TIMEOUT));

endmodule

// File: rtl/cd_host_comm.sv
// Host-side nibble-serial engine: per drive IRQ, receive a 10-nibble status packet,
// then send the 10-nibble command packet snapshotted from the CPU shadow.
module cd_host_comm
    import cd_comm_pkg::*;
#(
    parameter int unsigned HOLD    = 96,
    parameter int unsigned TIMEOUT = 16383
) (
    input  logic       CLK_12M,
    input  logic       nRESET,
    input  logic       CD_nIRQ,
    input  logic       CDCK,
    input  logic [3:0] CDD_DIN,
    output logic       HOCK,
    output logic [3:0] CDD_DOUT,
    input  logic       CMD_WE,
    input  logic [3:0] CMD_ADDR,
    input  logic [3:0] CMD_WDATA,
    input  logic [3:0] STAT_ADDR,
    output logic [3:0] STAT_RDATA,
    output logic       STAT_NEW,
    output logic       CHK_ERR,
    output logic       TO_ERR,
    output logic       BUSY,
    input  logic       ERR_CLR
);

    localparam logic [3:0] LAST_IDX = 4'(CHK_IDX);

    logic       nirq_m, nirq_s, cdck_m, cdck_s;
    logic [3:0] din_m, din_s;

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            nirq_m <= 1'b1;
            nirq_s <= 1'b1;
            cdck_m <= 1'b1;
            cdck_s <= 1'b1;
            din_m  <= 4'h0;
            din_s  <= 4'h0;
        end else begin
            nirq_m <= CD_nIRQ;
            nirq_s <= nirq_m;
            cdck_m <= CDCK;
            cdck_s <= cdck_m;
            din_m  <= CDD_DIN;
            din_s  <= din_m;
        end
    end

    logic [CHK_IDX-1:0][3:0] shadow_q;

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            shadow_q <= '0;
        end else if (CMD_WE && (CMD_ADDR < LAST_IDX)) begin
            shadow_q[CMD_ADDR] <= CMD_WDATA;
        end
    end

    cd_state_e               state_q, prev_q;
    logic [PKT_LEN-1:0][3:0] snap_q, rxbuf_q, status_q;
    logic [3:0]              idx_q;
    logic                    hock_q, busy_q, stat_new_q, chk_err_q, to_err_q;
    logic [3:0]              dout_q;
    logic                    wait_cond, wait_go, wait_to, restart;

    // First cycle in a new state clears the wait counters and is never acted on.
    assign restart = (state_q != prev_q);

    always_comb begin
        wait_cond = 1'b0;
        case (state_q)
            StAck:                    wait_cond = nirq_s;
            StRxWait, StTxLo:         wait_cond = !cdck_s;
            StRxAck, StTxHi:          wait_cond = cdck_s;
            StChk, StTxSetup, StDone: wait_cond = 1'b1;
            default:                  wait_cond = 1'b0;
        endcase
    end

    cd_hs_wait #(
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .CLK_12M (CLK_12M),
        .nRESET  (nRESET),
        .cond    (wait_cond),
        .restart (restart),
        .go      (wait_go),
        .timeout (wait_to)
    );

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= StIdle;
            prev_q     <= StIdle;
            snap_q     <= '0;
            rxbuf_q    <= '0;
            status_q   <= '0;
            idx_q      <= 4'h0;
            hock_q     <= 1'b1;
            busy_q     <= 1'b0;
            stat_new_q <= 1'b0;
            chk_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
            dout_q     <= 4'h0;
        end else begin
            prev_q     <= state_q;
            stat_new_q <= 1'b0;
            // Clear first so a set later in this cycle takes priority.
            if (ERR_CLR) begin
                chk_err_q <= 1'b0;
                to_err_q  <= 1'b0;
            end
            case (state_q)
                StIdle, StRecover: begin
                    if (!nirq_s) begin
                        snap_q  <= {cd_nibble_chk(shadow_q), shadow_q};
                        hock_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StAck;
                    end else if (state_q == StRecover) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    if (!restart && wait_go) begin
                        case (state_q)
                            StAck: begin
                                idx_q   <= 4'h0;
                                state_q <= StRxWait;
                            end
                            StRxWait: begin
                                rxbuf_q[idx_q] <= din_s;
                                hock_q         <= 1'b1;
                                state_q        <= StRxAck;
                            end
                            StRxAck: begin
                                hock_q <= 1'b0;
                                if (idx_q != LAST_IDX) begin
                                    idx_q   <= idx_q + 4'd1;
                                    state_q <= StRxWait;
                                end else begin
                                    if (cd_nibble_chk(rxbuf_q[CHK_IDX-1:0]) == rxbuf_q[CHK_IDX]) begin
                                        status_q   <= rxbuf_q;
                                        stat_new_q <= 1'b1;
                                    end else begin
                                        chk_err_q <= 1'b1;
                                    end
                                    state_q <= StChk;
                                end
                            end
                            StChk: begin
                                idx_q   <= 4'h0;
                                dout_q  <= snap_q[0];
                                state_q <= StTxSetup;
                            end
                            StTxSetup: begin
                                hock_q  <= 1'b1;
                                state_q <= StTxHi;
                            end
                            StTxHi: begin
                                hock_q  <= 1'b0;
                                state_q <= StTxLo;
                            end
                            StTxLo: begin
                                if (idx_q != LAST_IDX) begin
                                    idx_q   <= idx_q + 4'd1;
                                    dout_q  <= snap_q[idx_q + 4'd1];
                                    state_q <= StTxSetup;
                                end else begin
                                    state_q <= StDone;
                                end
                            end
                            StDone: begin
                                hock_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end else if (!restart && wait_to) begin
                        to_err_q <= 1'b1;
                        hock_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StRecover;
                    end
                end
            endcase
        end
    end

    assign HOCK       = hock_q;
    assign CDD_DOUT   = dout_q;
    assign STAT_NEW   = stat_new_q;
    assign CHK_ERR    = chk_err_q;
    assign TO_ERR     = to_err_q;
    assign BUSY       = busy_q;
    assign STAT_RDATA = (STAT_ADDR <= LAST_IDX) ? status_q[STAT_ADDR] : 4'h0;

endmodule

// File: tb/tb_cd_host_comm.sv
// Self-checking bench: a behavioural CDD drive model exchanges packets with the host engine.
module tb_cd_host_comm;

    localparam int unsigned HOLD       = 6;
    localparam int unsigned TIMEOUT    = 600;
    localparam int          WAIT_LIMIT = 2000;

    logic       CLK_12M = 1'b0;
    logic       nRESET = 1'b0;
    logic       CD_nIRQ = 1'b1;
    logic       CDCK = 1'b1;
    logic [3:0] CDD_DIN = 4'h0;
    logic       HOCK;
    logic [3:0] CDD_DOUT;
    logic       CMD_WE = 1'b0;
    logic [3:0] CMD_ADDR = 4'h0;
    logic [3:0] CMD_WDATA = 4'h0;
    logic [3:0] STAT_ADDR = 4'h0;
    logic [3:0] STAT_RDATA;
    logic       STAT_NEW;
    logic       CHK_ERR;
    logic       TO_ERR;
    logic       BUSY;
    logic       ERR_CLR = 1'b0;

    cd_host_comm #(
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK_12M    (CLK_12M),
        .nRESET     (nRESET),
        .CD_nIRQ    (CD_nIRQ),
        .CDCK       (CDCK),
        .CDD_DIN    (CDD_DIN),
        .HOCK       (HOCK),
        .CDD_DOUT   (CDD_DOUT),
        .CMD_WE     (CMD_WE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .STAT_ADDR  (STAT_ADDR),
        .STAT_RDATA (STAT_RDATA),
        .STAT_NEW   (STAT_NEW),
        .CHK_ERR    (CHK_ERR),
        .TO_ERR     (TO_ERR),
        .BUSY       (BUSY),
        .ERR_CLR    (ERR_CLR)
    );

    always #5 CLK_12M = ~CLK_12M;

    int   n_checks = 0;
    int   n_pass = 0;
    int   stat_new_cnt = 0;
    bit   abort = 1'b0;
    int   freeze_at = -1;
    int   stop_tx_at = -1;
    logic [3:0] m_shadow [9];
    logic [3:0] m_status [10];
    bit         m_chk_err, m_to_err;
    logic [3:0] drv_stat [10];
    logic [3:0] drv_cap [10];
    logic [3:0] exp_cmd [10];

    always @(posedge CLK_12M) if (STAT_NEW === 1'b1) stat_new_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        n_checks++;
        if (obsv === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obsv, expv);
    endtask

    function automatic logic [3:0] nib_chk(input int sum);
        return 4'(15 - ((sum + 5) % 16));
    endfunction

    function automatic logic [3:0] chk_of_status();
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(drv_stat[k]);
        return nib_chk(s);
    endfunction

    function automatic logic [3:0] chk_of_shadow();
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(m_shadow[k]);
        return nib_chk(s);
    endfunction

    task automatic tick();
        @(posedge CLK_12M);
        #1;
    endtask

    task automatic rand_gap();
        repeat ($urandom_range(0, 6)) tick();
    endtask

    task automatic wait_hock(input logic v, input string tag);
        int n = 0;
        if (abort) return;
        while (HOCK !== v && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (HOCK !== v) begin
            check_eq({"wait_", tag}, 32'(HOCK), 32'(v));
            abort = 1'b1;
        end
    endtask

    // Drive side of one transaction; CD_nIRQ is already low on entry.
    task automatic cdd_xfer();
        wait_hock(1'b0, "ack");
        rand_gap();
        CD_nIRQ = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == freeze_at) return;
            wait_hock(1'b0, "rx_req");
            CDD_DIN = drv_stat[k];
            rand_gap();
            CDCK = 1'b0;
            wait_hock(1'b1, "rx_ack");
            rand_gap();
            CDD_DIN = 4'($urandom_range(0, 15));
            CDCK = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            wait_hock(1'b0, "tx_lo");
            wait_hock(1'b1, "tx_hi");
            drv_cap[k] = CDD_DOUT;
            if (k == stop_tx_at) return;
            rand_gap();
            CDCK = 1'b1;
            wait_hock(1'b0, "tx_ack");
            rand_gap();
            CDCK = 1'b0;
        end
        wait_hock(1'b1, "done");
        CDCK = 1'b1;
    endtask

    task automatic cpu_write(input int addr, input int data);
        CMD_ADDR = 4'(addr);
        CMD_WDATA = 4'(data);
        CMD_WE = 1'b1;
        tick();
        CMD_WE = 1'b0;
        if (addr < 9) m_shadow[addr] = 4'(data);
    endtask

    task automatic err_clr();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        m_chk_err = 1'b0;
        m_to_err = 1'b0;
    endtask

    task automatic prep_status(input bit corrupt);
        drv_stat[9] = chk_of_status();
        if (corrupt) drv_stat[9] = drv_stat[9] ^ 4'($urandom_range(1, 15));
    endtask

    task automatic fill_random_status();
        for (int k = 0; k < 9; k++) drv_stat[k] = 4'($urandom_range(0, 15));
    endtask

    // race_val >= 0 writes shadow[2] in exactly the cycle the host snapshots.
    task automatic launch(input int race_val);
        for (int k = 0; k < 9; k++) exp_cmd[k] = m_shadow[k];
        exp_cmd[9] = chk_of_shadow();
        CD_nIRQ = 1'b0;
        if (race_val >= 0) begin
            tick();
            tick();
            CMD_ADDR = 4'd2;
            CMD_WDATA = 4'(race_val);
            CMD_WE = 1'b1;
            tick();
            CMD_WE = 1'b0;
            m_shadow[2] = 4'(race_val);
            check_eq("snap_edge_hock", 32'(HOCK), 32'd0);
        end
        cdd_xfer();
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < 10; a++) begin
            STAT_ADDR = 4'(a);
            #1;
            check_eq($sformatf("%s_stat[%0d]", tag, a), 32'(STAT_RDATA), 32'(m_status[a]));
        end
    endtask

    task automatic run_pkt(input bit corrupt, input int race_val, input string tag);
        int cnt0;
        prep_status(corrupt);
        cnt0 = stat_new_cnt;
        launch(race_val);
        for (int k = 0; k < 10; k++)
            check_eq($sformatf("%s_cmd[%0d]", tag, k), 32'(drv_cap[k]), 32'(exp_cmd[k]));
        if (corrupt) m_chk_err = 1'b1;
        else for (int k = 0; k < 10; k++) m_status[k] = drv_stat[k];
        check_eq({tag, "_stat_new"}, 32'(stat_new_cnt - cnt0), corrupt ? 32'd0 : 32'd1);
        check_eq({tag, "_chk_err"}, 32'(CHK_ERR), 32'(m_chk_err));
        check_eq({tag, "_to_err"}, 32'(TO_ERR), 32'(m_to_err));
        check_eq({tag, "_hock"}, 32'(HOCK), 32'd1);
        check_eq({tag, "_busy"}, 32'(BUSY), 32'd0);
        readback(tag);
    endtask

    initial begin
        int cnt0;
        int n;
        int race;
        for (int k = 0; k < 9; k++) m_shadow[k] = 4'h0;
        for (int k = 0; k < 10; k++) m_status[k] = 4'h0;
        m_chk_err = 1'b0;
        m_to_err = 1'b0;

        repeat (3) tick();
        check_eq("rst_hock", 32'(HOCK), 32'd1);
        check_eq("rst_dout", 32'(CDD_DOUT), 32'd0);
        check_eq("rst_stat_new", 32'(STAT_NEW), 32'd0);
        check_eq("rst_chk_err", 32'(CHK_ERR), 32'd0);
        check_eq("rst_to_err", 32'(TO_ERR), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        readback("rst");
        nRESET = 1'b1;
        repeat (4) tick();

        for (int k = 0; k < 9; k++) drv_stat[k] = 4'(k + 1);
        run_pkt(1'b0, -1, "loop");

        for (int a = 0; a < 9; a++) cpu_write(a, 3);
        cpu_write(12, 5);
        fill_random_status();
        run_pkt(1'b0, -1, "all3");

        for (int t = 0; t < 4; t++) begin
            repeat (4) cpu_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            fill_random_status();
            run_pkt($urandom_range(0, 2) == 0, -1, $sformatf("rnd%0d", t));
            if (m_chk_err) begin
                err_clr();
                check_eq("rnd_chk_clr", 32'(CHK_ERR), 32'd0);
            end
        end

        fill_random_status();
        run_pkt(1'b1, -1, "bad");
        err_clr();
        check_eq("bad_chk_clr", 32'(CHK_ERR), 32'd0);

        fill_random_status();
        prep_status(1'b0);
        cnt0 = stat_new_cnt;
        freeze_at = 4;
        launch(-1);
        freeze_at = -1;
        n = 0;
        while (TO_ERR !== 1'b1 && n < int'(TIMEOUT) + 300) begin
            tick();
            n++;
        end
        repeat (8) tick();
        m_to_err = 1'b1;
        check_eq("frz_to_err", 32'(TO_ERR), 32'd1);
        check_eq("frz_hock", 32'(HOCK), 32'd1);
        check_eq("frz_busy", 32'(BUSY), 32'd0);
        check_eq("frz_stat_new", 32'(stat_new_cnt - cnt0), 32'd0);
        readback("frz");
        err_clr();
        check_eq("frz_to_clr", 32'(TO_ERR), 32'd0);
        fill_random_status();
        run_pkt(1'b0, -1, "after_frz");

        race = (int'(m_shadow[2]) + 1) % 16;
        fill_random_status();
        run_pkt(1'b0, race, "race");
        fill_random_status();
        run_pkt(1'b0, -1, "race_next");

        fill_random_status();
        prep_status(1'b0);
        stop_tx_at = 3;
        launch(-1);
        stop_tx_at = -1;
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("pre_rst_cmd[%0d]", k), 32'(drv_cap[k]), 32'(exp_cmd[k]));
        #3;
        nRESET = 1'b0;
        #1;
        check_eq("mid_rst_hock", 32'(HOCK), 32'd1);
        check_eq("mid_rst_dout", 32'(CDD_DOUT), 32'd0);
        check_eq("mid_rst_busy", 32'(BUSY), 32'd0);
        for (int k = 0; k < 9; k++) m_shadow[k] = 4'h0;
        for (int k = 0; k < 10; k++) m_status[k] = 4'h0;
        m_chk_err = 1'b0;
        m_to_err = 1'b0;
        CD_nIRQ = 1'b1;
        CDCK = 1'b1;
        CDD_DIN = 4'h0;
        readback("mid_rst");
        repeat (2) tick();
        nRESET = 1'b1;
        repeat (4) tick();
        fill_random_status();
        run_pkt(1'b0, -1, "after_rst");

        for (int t = 0; t < 3; t++) begin
            STAT_ADDR = 4'($urandom_range(10, 15));
            #1;
            check_eq("stat_oob", 32'(STAT_RDATA), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
